// File: rtl/sdpsram.sv
// Simple dual-port synchronous SRAM: one write port with byte enables, one read port
// with a 1- or 2-cycle registered read path. Define SDPSRAM_BYPASS_EN for write-first collisions.
module sdpsram #(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6,
    parameter int RD_LAT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_wen,
    input  logic [BW_ADDR-1:0]   i_waddr,
    input  logic [BW_DATA-1:0]   i_wdata,
    input  logic [BW_DATA/8-1:0] i_wbe,
    input  logic                 i_ren,
    input  logic [BW_ADDR-1:0]   i_raddr,
    input  logic                 i_oen,
    output logic [BW_DATA-1:0]   o_rdata,
    output logic                 o_rvalid
);
    localparam int NB    = BW_DATA / 8;
    localparam int DEPTH = 2 ** BW_ADDR;

    logic [BW_DATA-1:0] mem [DEPTH];
    logic [BW_DATA-1:0] rd_word;
    logic [BW_DATA-1:0] s1_data_reg;
    logic               s1_valid_reg;
    logic [BW_DATA-1:0] out_data;
    logic               out_valid;

    // Array is never reset so it maps onto block RAM and survives a reset pulse.
    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wbe[b]) begin
                    mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef SDPSRAM_BYPASS_EN
    logic collide;
    assign collide = i_wen && (i_waddr == i_raddr);

    // Write-first: enabled bytes of a same-address write replace the old word in the read.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bypass
            assign rd_word[8*gi +: 8] = (collide && i_wbe[gi]) ? i_wdata[8*gi +: 8]
                                                               : mem[i_raddr][8*gi +: 8];
        end
    endgenerate
`else
    // Read-first: the write lands after this sample, so the old word is returned.
    assign rd_word = mem[i_raddr];
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= i_ren;
            if (i_ren) begin
                s1_data_reg <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign out_data  = s1_data_reg;
            assign out_valid = s1_valid_reg;
        end else begin : g_lat2
            logic [BW_DATA-1:0] s2_data_reg;
            logic               s2_valid_reg;

            // Second stage only loads on a completing read so the output holds otherwise.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    s2_data_reg  <= '0;
                    s2_valid_reg <= 1'b0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data_reg;
                    end
                end
            end

            assign out_data  = s2_data_reg;
            assign out_valid = s2_valid_reg;
        end
    endgenerate

    assign o_rdata  = i_oen ? out_data : '0;
    assign o_rvalid = out_valid;

endmodule

// File: tb/tb_sdpsram.sv
// Directed bench for sdpsram: drives one RD_LAT=1 and one RD_LAT=2 instance with the
// same stimulus and checks each against hand-computed values.
module tb_sdpsram;
    logic        clk;
    logic        rstn;
    logic        wen;
    logic [5:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic        ren;
    logic [5:0]  raddr;
    logic        oen;
    logic [63:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;

    int checks   = 0;
    int failures = 0;

`ifdef SDPSRAM_BYPASS_EN
    localparam logic [63:0] COLL_EXP = 64'hB;
`else
    localparam logic [63:0] COLL_EXP = 64'hA;
`endif

    sdpsram #(.BW_DATA(64), .BW_ADDR(6), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_wbe(wbe), .i_ren(ren), .i_raddr(raddr), .i_oen(oen),
        .o_rdata(rdata1), .o_rvalid(rvalid1)
    );

    sdpsram #(.BW_DATA(64), .BW_ADDR(6), .RD_LAT(2)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_wbe(wbe), .i_ren(ren), .i_raddr(raddr), .i_oen(oen),
        .o_rdata(rdata2), .o_rvalid(rvalid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        ren = 1'b1; raddr = 6'd0; oen = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rdata1 !== 64'h0 || rvalid1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold_lat1 cycle=%0d rdata=%h rvalid=%b want 0/0", c, rdata1, rvalid1);
            end
            checks++;
            if (rdata2 !== 64'h0 || rvalid2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold_lat2 cycle=%0d rdata=%h rvalid=%b want 0/0", c, rdata2, rvalid2);
            end
        end
        rstn = 1'b1;
        tick();
        ren = 1'b0;
        checks++;
        if (rvalid1 !== 1'b1 || rvalid2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_first rvalid1=%b rvalid2=%b want 1/0", rvalid1, rvalid2);
        end
        tick();
        checks++;
        if (rvalid1 !== 1'b0 || rvalid2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_second rvalid1=%b rvalid2=%b want 0/1", rvalid1, rvalid2);
        end
        tick();
        checks++;
        if (rvalid2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_pulse rvalid2=%b want 0", rvalid2);
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_fill_readback();
        for (int a = 0; a < 64; a++) begin
            wen = 1'b1; waddr = 6'(a); wdata = 64'(a); wbe = 8'hFF;
            tick();
        end
        wen = 1'b0;
        for (int a = 0; a <= 64; a++) begin
            ren   = (a < 64);
            raddr = 6'(a);
            tick();
            if (a < 64) begin
                checks++;
                if (rvalid1 !== 1'b1 || rdata1 !== 64'(a)) begin
                    failures++;
                    $display("FAIL readback_lat1 addr=%0d rdata=%h rvalid=%b want %h/1", a, rdata1, rvalid1, 64'(a));
                end
            end else begin
                checks++;
                if (rvalid1 !== 1'b0) begin
                    failures++;
                    $display("FAIL readback_lat1_end rvalid=%b want 0", rvalid1);
                end
            end
            if (a >= 1) begin
                checks++;
                if (rvalid2 !== 1'b1 || rdata2 !== 64'(a - 1)) begin
                    failures++;
                    $display("FAIL readback_lat2 addr=%0d rdata=%h rvalid=%b want %h/1", a - 1, rdata2, rvalid2, 64'(a - 1));
                end
            end else begin
                checks++;
                if (rvalid2 !== 1'b0) begin
                    failures++;
                    $display("FAIL readback_lat2_start rvalid=%b want 0", rvalid2);
                end
            end
        end
        ren = 1'b0;
        tick();
        $display("test_fill_readback done checks=%0d", checks);
    endtask

    task automatic test_byte_enable();
        wen = 1'b1; waddr = 6'd5; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wbe = 8'hFF;
        tick();
        wdata = 64'h1122_3344_5566_7788; wbe = 8'h0F;
        tick();
        // wbe all zero must leave addr 6 (=6) untouched
        waddr = 6'd6; wdata = 64'hDEAD_BEEF_DEAD_BEEF; wbe = 8'h00;
        tick();
        wen = 1'b0;
        ren = 1'b1; raddr = 6'd5;
        tick();
        raddr = 6'd6;
        checks++;
        if (rdata1 !== 64'hFFFF_FFFF_5566_7788) begin
            failures++;
            $display("FAIL byte_enable_lat1 rdata=%h want ffffffff55667788", rdata1);
        end
        tick();
        ren = 1'b0;
        checks++;
        if (rdata2 !== 64'hFFFF_FFFF_5566_7788) begin
            failures++;
            $display("FAIL byte_enable_lat2 rdata=%h want ffffffff55667788", rdata2);
        end
        checks++;
        if (rdata1 !== 64'd6) begin
            failures++;
            $display("FAIL zero_wbe_lat1 rdata=%h want 6", rdata1);
        end
        tick();
        checks++;
        if (rdata2 !== 64'd6) begin
            failures++;
            $display("FAIL zero_wbe_lat2 rdata=%h want 6", rdata2);
        end
        $display("test_byte_enable done checks=%0d", checks);
    endtask

    task automatic test_collision();
        wen = 1'b1; waddr = 6'd9; wdata = 64'hA; wbe = 8'hFF;
        tick();
        wdata = 64'hB; ren = 1'b1; raddr = 6'd9;
        tick();
        wen = 1'b0;
        checks++;
        if (rdata1 !== COLL_EXP) begin
            failures++;
            $display("FAIL collision_lat1 rdata=%h want %h", rdata1, COLL_EXP);
        end
        tick();
        ren = 1'b0;
        checks++;
        if (rdata1 !== 64'hB) begin
            failures++;
            $display("FAIL collision_after_lat1 rdata=%h want b", rdata1);
        end
        checks++;
        if (rdata2 !== COLL_EXP) begin
            failures++;
            $display("FAIL collision_lat2 rdata=%h want %h", rdata2, COLL_EXP);
        end
        tick();
        checks++;
        if (rdata2 !== 64'hB) begin
            failures++;
            $display("FAIL collision_after_lat2 rdata=%h want b", rdata2);
        end
        // A write one cycle after the read sampled must not reach the RD_LAT=2 result
        ren = 1'b1; raddr = 6'd10;
        tick();
        ren = 1'b0; wen = 1'b1; waddr = 6'd10; wdata = 64'hCC;
        tick();
        wen = 1'b0;
        checks++;
        if (rdata2 !== 64'd10 || rvalid2 !== 1'b1) begin
            failures++;
            $display("FAIL late_write_lat2 rdata=%h rvalid=%b want a/1", rdata2, rvalid2);
        end
        $display("test_collision done checks=%0d", checks);
    endtask

    task automatic test_output_enable();
        oen = 1'b0; ren = 1'b1; raddr = 6'd3;
        tick();
        ren = 1'b0;
        checks++;
        if (rdata1 !== 64'h0 || rvalid1 !== 1'b1) begin
            failures++;
            $display("FAIL oen_low_lat1 rdata=%h rvalid=%b want 0/1", rdata1, rvalid1);
        end
        tick();
        checks++;
        if (rdata2 !== 64'h0 || rvalid2 !== 1'b1) begin
            failures++;
            $display("FAIL oen_low_lat2 rdata=%h rvalid=%b want 0/1", rdata2, rvalid2);
        end
        oen = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 64'd3 || rdata2 !== 64'd3) begin
            failures++;
            $display("FAIL oen_high rdata1=%h rdata2=%h want 3/3", rdata1, rdata2);
        end
        tick();
        $display("test_output_enable done checks=%0d", checks);
    endtask

    task automatic test_midop_reset();
        for (int a = 1; a <= 3; a++) begin
            ren = 1'b1; raddr = 6'(a);
            tick();
        end
        ren  = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0 || rdata1 !== 64'h0 || rdata2 !== 64'h0) begin
            failures++;
            $display("FAIL midop_reset_assert rvalid=%b/%b rdata=%h/%h want 0", rvalid1, rvalid2, rdata1, rdata2);
        end
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
                failures++;
                $display("FAIL midop_no_valid cycle=%0d rvalid=%b/%b want 0/0", c, rvalid1, rvalid2);
            end
        end
        for (int a = 1; a <= 4; a++) begin
            ren = (a <= 3); raddr = 6'(a);
            tick();
            if (a <= 3) begin
                checks++;
                if (rvalid1 !== 1'b1 || rdata1 !== 64'(a)) begin
                    failures++;
                    $display("FAIL midop_readback_lat1 addr=%0d rdata=%h want %h", a, rdata1, 64'(a));
                end
            end
            if (a >= 2) begin
                checks++;
                if (rvalid2 !== 1'b1 || rdata2 !== 64'(a - 1)) begin
                    failures++;
                    $display("FAIL midop_readback_lat2 addr=%0d rdata=%h want %h", a - 1, rdata2, 64'(a - 1));
                end
            end
        end
        ren = 1'b0;
        tick();
        $display("test_midop_reset done checks=%0d", checks);
    endtask

    initial begin
        test_reset();
        test_fill_readback();
        test_byte_enable();
        test_collision();
        test_output_enable();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
